// File: rtl/reg_window_if.sv
// Register-window controller bus: CPU call/return handshake, register-file
// access port and spill/fill memory port, bundled for one connection.
interface reg_window_if;
  logic        call;
  logic        ret;
  logic        busy;
  logic [1:0]  cwp;
  logic        err;
  logic [1:0]  rf_wnd;
  logic [1:0]  rf_reg;
  logic        rf_wen;
  logic        rf_ldwnd;
  logic [15:0] rf_rdata;
  logic [15:0] rf_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  // Controller side
  modport slave (
    input  call, ret, rf_rdata, mem_rdata, mem_ack,
    output busy, cwp, err, rf_wnd, rf_reg, rf_wen, rf_ldwnd, rf_wdata,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  // CPU / register file / memory side
  modport master (
    output call, ret, rf_rdata, mem_rdata, mem_ack,
    input  busy, cwp, err, rf_wnd, rf_reg, rf_wen, rf_ldwnd, rf_wdata,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/reg_window_ctrl.sv
// Register-window controller: 4 logical windows over 8 physical registers,
// at most 3 resident. Overflowing a call spills the 2 non-overlapping
// registers of the oldest window to a memory stack; underflowing a return
// refills them before the window pointer moves back.
module reg_window_ctrl #(
  parameter logic [7:0] STACK_BASE  = 8'hC0,
  parameter int         STACK_WORDS = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  reg_window_if.slave bus
);

  localparam int SPW = $clog2(STACK_WORDS + 1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_WORDS);
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
  localparam logic [SPW-1:0] SP_TWO  = SPW'(2);

  typedef enum logic [2:0] {
    IDLE, SPILL_R0, SPILL_R1, FILL_R1, FILL_R0, SWITCH
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     cwp_q, cwp_d;
  logic [1:0]     res_q, res_d;     // resident window count, 1..3
  logic [SPW-1:0] sp_q, sp_d;       // spill stack fill in words
  logic           err_q, err_d;
  logic [1:0]     tgt_q, tgt_d;     // window the SWITCH cycle loads

  logic        busy;
  logic [1:0]  rf_wnd, rf_reg;
  logic        rf_wen, rf_ldwnd;
  logic [15:0] rf_wdata;
  logic        mem_req, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;

  // State registers; reset aborts any transfer in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cwp_q   <= 2'd0;
      res_q   <= 2'd1;
      sp_q    <= '0;
      err_q   <= 1'b0;
      tgt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cwp_q   <= cwp_d;
      res_q   <= res_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
      tgt_q   <= tgt_d;
    end
  end

  // Next-state decode and per-state register-file / memory drive
  always_comb begin
    state_d   = state_q;
    cwp_d     = cwp_q;
    res_d     = res_q;
    sp_d      = sp_q;
    err_d     = err_q;
    tgt_d     = tgt_q;
    busy      = 1'b1;
    rf_wnd    = cwp_q;
    rf_reg    = 2'd0;
    rf_wen    = 1'b0;
    rf_ldwnd  = 1'b0;
    rf_wdata  = 16'h0000;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 8'h00;
    mem_wdata = 16'h0000;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        // simultaneous call and ret is treated as no request
        if (bus.call && !bus.ret) begin
          if (res_q < 2'd3) begin
            tgt_d   = cwp_q + 2'd1;
            res_d   = res_q + 2'd1;
            state_d = SWITCH;
          end else if (sp_q < SP_FULL) begin
            state_d = SPILL_R0;
          end else begin
            err_d = 1'b1;
          end
        end else if (bus.ret && !bus.call) begin
          if (res_q > 2'd1) begin
            tgt_d   = cwp_q - 2'd1;
            res_d   = res_q - 2'd1;
            state_d = SWITCH;
          end else if (sp_q >= SP_TWO) begin
            state_d = FILL_R1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      SPILL_R0, SPILL_R1: begin
        // oldest resident window is two behind the current one
        rf_wnd    = cwp_q - 2'd2;
        rf_reg    = (state_q == SPILL_R1) ? 2'd1 : 2'd0;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = STACK_BASE + 8'(sp_q);
        mem_wdata = bus.rf_rdata;
        if (bus.mem_ack) begin
          sp_d = sp_q + SP_ONE;
          if (state_q == SPILL_R0) begin
            state_d = SPILL_R1;
          end else begin
            tgt_d   = cwp_q + 2'd1;
            state_d = SWITCH;
          end
        end
      end

      FILL_R1, FILL_R0: begin
        // stack top holds reg1 (pushed last), so it is restored first
        rf_wnd   = cwp_q - 2'd1;
        rf_reg   = (state_q == FILL_R1) ? 2'd1 : 2'd0;
        rf_wen   = bus.mem_ack;
        rf_wdata = bus.mem_rdata;
        mem_req  = 1'b1;
        mem_addr = STACK_BASE + 8'(sp_q) - 8'd1;
        if (bus.mem_ack) begin
          sp_d = sp_q - SP_ONE;
          if (state_q == FILL_R1) begin
            state_d = FILL_R0;
          end else begin
            tgt_d   = cwp_q - 2'd1;
            state_d = SWITCH;
          end
        end
      end

      SWITCH: begin
        rf_wnd   = tgt_q;
        rf_ldwnd = 1'b1;
        cwp_d    = tgt_q;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy      = busy;
  assign bus.cwp       = cwp_q;
  assign bus.err       = err_q;
  assign bus.rf_wnd    = rf_wnd;
  assign bus.rf_reg    = rf_reg;
  assign bus.rf_wen    = rf_wen;
  assign bus.rf_ldwnd  = rf_ldwnd;
  assign bus.rf_wdata  = rf_wdata;
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_reg_window_ctrl.sv
// Bench for reg_window_ctrl: models the register file and memory, drives
// directed and random call/ret sequences, and compares against a stack-based
// reference of window pointer, residency, spill stack and register contents.
module tb_reg_window_ctrl;

  localparam int         SW   = 8;
  localparam logic [7:0] BASE = 8'hC0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_window_if bus ();

  reg_window_ctrl #(.STACK_BASE(BASE), .STACK_WORDS(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Environment: physical register file and memory
  logic [15:0] phys [8];
  logic [15:0] mem  [256];
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  logic        cpu_we = 1'b0;
  logic [2:0]  cpu_idx = 3'd0;
  logic [15:0] cpu_data = 16'h0;
  logic [2:0]  rf_idx;

  assign rf_idx        = 3'(bus.rf_reg) + {bus.rf_wnd, 1'b0};
  assign bus.rf_rdata  = phys[rf_idx];
  assign bus.mem_rdata = mem[bus.mem_addr];
  assign bus.mem_ack   = bus.mem_req && (wait_cnt == ack_delay);

  always @(posedge clk) begin
    if (cpu_we) phys[cpu_idx] <= cpu_data;
    if (bus.rf_wen) phys[rf_idx] <= bus.rf_wdata;
    if (bus.mem_req && bus.mem_ack && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (!rst_n || !bus.mem_req || bus.mem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  // Reference model
  int m_cwp, m_res, m_sp, m_err;
  logic [15:0] m_phys [8];
  logic [15:0] m_stack [$];

  int total = 0;
  int bad   = 0;
  int last_reqc, last_ldc, last_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cwp = 0; m_res = 1; m_sp = 0; m_err = 0;
    m_stack.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; bus.call = 1'b0; bus.ret = 1'b0; ack_delay = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic cpu_write(input int idx, input logic [15:0] data);
    @(negedge clk);
    cpu_we = 1'b1; cpu_idx = 3'(idx); cpu_data = data;
    @(negedge clk);
    cpu_we = 1'b0;
    m_phys[idx] = data;
  endtask

  // One call/ret request with memory latency d; checks every transfer
  task automatic do_op(input bit c, input bit r, input int d);
    int exp_busy, n, w;
    logic [15:0] val;
    int ea[$], ewe[$], ewnd[$], ereg[$];
    logic [15:0] ed[$];
    bit pend;
    logic [7:0] p_addr; logic [15:0] p_wd; logic [1:0] p_reg, p_wnd;
    exp_busy = 0;
    if (c && !r) begin
      if (m_res < 3) begin
        m_cwp = (m_cwp + 1) % 4; m_res++; exp_busy = 1;
      end else if (m_sp < SW) begin
        w = (m_cwp + 2) % 4;
        for (int k = 0; k < 2; k++) begin
          val = m_phys[(k + 2 * w) % 8];
          ea.push_back(BASE + m_sp); ewe.push_back(1); ed.push_back(val);
          ewnd.push_back(w); ereg.push_back(k);
          m_stack.push_back(val); m_sp++;
        end
        m_cwp = (m_cwp + 1) % 4; exp_busy = 2 * (d + 1) + 1;
      end else m_err = 1;
    end else if (r && !c) begin
      if (m_res > 1) begin
        m_cwp = (m_cwp + 3) % 4; m_res--; exp_busy = 1;
      end else if (m_sp >= 2) begin
        w = (m_cwp + 3) % 4;
        for (int k = 1; k >= 0; k--) begin
          val = m_stack.pop_back();
          ea.push_back(BASE + m_sp - 1); ewe.push_back(0); ed.push_back(val);
          ewnd.push_back(w); ereg.push_back(k);
          m_phys[(k + 2 * w) % 8] = val; m_sp--;
        end
        m_cwp = w; exp_busy = 2 * (d + 1) + 1;
      end else m_err = 1;
    end

    @(negedge clk);
    ack_delay = d; bus.call = c; bus.ret = r;
    @(posedge clk); #1;
    bus.call = 1'b0; bus.ret = 1'b0;
    n = 0; last_reqc = 0; last_ldc = 0; pend = 1'b0;
    while (bus.busy && n < 40) begin
      n++;
      if (bus.rf_ldwnd) last_ldc++;
      if (bus.mem_req) begin
        last_reqc++;
        if (pend) begin
          chk("hold_addr", bus.mem_addr, p_addr);
          chk("hold_wdata", bus.mem_wdata, p_wd);
          chk("hold_reg", bus.rf_reg, p_reg);
          chk("hold_wnd", bus.rf_wnd, p_wnd);
        end
        if (bus.mem_ack) begin
          if (ea.size() == 0) begin
            total++; bad++;
            $error("FAIL extra_xfer observed=%0h expected=none", bus.mem_addr);
          end else begin
            chk("xfer_addr", bus.mem_addr, ea.pop_front());
            chk("xfer_we", bus.mem_we, ewe[0]);
            chk("xfer_wnd", bus.rf_wnd, ewnd.pop_front());
            chk("xfer_reg", bus.rf_reg, ereg.pop_front());
            if (ewe[0] == 1) chk("spill_data", bus.mem_wdata, ed[0]);
            else begin
              chk("fill_data", bus.rf_wdata, ed[0]);
              chk("fill_wen", bus.rf_wen, 1);
            end
            void'(ewe.pop_front()); void'(ed.pop_front());
          end
        end
        pend = !bus.mem_ack;
        p_addr = bus.mem_addr; p_wd = bus.mem_wdata; p_reg = bus.rf_reg; p_wnd = bus.rf_wnd;
      end else pend = 1'b0;
      @(posedge clk); #1;
    end
    last_busy = n;
    chk("busy_cycles", n, exp_busy);
    chk("cwp", bus.cwp, m_cwp);
    chk("err", bus.err, m_err);
    chk("ldwnd_pulses", last_ldc, (exp_busy > 0) ? 1 : 0);
    chk("xfers_left", ea.size(), 0);
    if (exp_busy <= 1) chk("no_mem_req", last_reqc, 0);
    for (int i = 0; i < 8; i++) chk("phys", phys[i], m_phys[i]);
    $display("op call=%0b ret=%0b delay=%0d busy=%0d cwp=%0d err=%0d sp=%0d",
             c, r, d, n, bus.cwp, bus.err, m_sp);
  endtask

  initial begin
    int n;
    bit c, r;
    bus.call = 1'b0; bus.ret = 1'b0;
    for (int i = 0; i < 8; i++) m_phys[i] = 16'h0;
    do_reset();
    #1;
    chk("rst_cwp", bus.cwp, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_rf_wen", bus.rf_wen, 0);
    chk("rst_ldwnd", bus.rf_ldwnd, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    for (int i = 0; i < 8; i++) cpu_write(i, 16'h1000 + 16'(i));
    cpu_write(0, 16'hAAAA);
    cpu_write(1, 16'h5555);

    // Two calls without memory traffic, then an overflowing third call
    do_op(1, 0, 0);
    do_op(1, 0, 0);
    chk("two_calls_cwp", bus.cwp, 2);
    chk("two_calls_ld", last_ldc, 1);
    do_op(1, 0, 0);
    chk("spill_c0", mem[8'hC0], 16'hAAAA);
    chk("spill_c1", mem[8'hC1], 16'h5555);
    chk("spill_cwp", bus.cwp, 3);
    chk("spill_busy", last_busy, 3);
    cpu_write(0, 16'h0000);
    cpu_write(1, 16'h0000);
    do_op(0, 1, 0);
    do_op(0, 1, 0);
    do_op(0, 1, 0);
    chk("fill_cwp", bus.cwp, 0);
    chk("fill_phys0", phys[0], 16'hAAAA);
    chk("fill_phys1", phys[1], 16'h5555);

    // Underflow straight after reset, then a legal call
    do_reset();
    do_op(0, 1, 0);
    chk("uflow_err", bus.err, 1);
    chk("uflow_cwp", bus.cwp, 0);
    chk("uflow_noreq", last_reqc, 0);
    do_op(1, 0, 0);
    chk("after_err_cwp", bus.cwp, 1);
    chk("err_sticky", bus.err, 1);

    // Slow memory during a spill
    do_op(1, 0, 0);
    do_op(1, 0, 3);
    chk("slow_spill_busy", last_busy, 9);

    // Random traffic with periodic resets
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int i = 0; i < 40; i++) begin
        n = $urandom_range(0, 19);
        c = (n < 9) || (n >= 18);
        r = (n >= 9);
        if ($urandom_range(0, 4) == 0) cpu_write($urandom_range(0, 7), 16'($urandom));
        do_op(c, r, $urandom_range(0, 2));
      end
    end

    // Reset in the middle of the second spill transfer
    do_reset();
    do_op(1, 0, 0);
    do_op(1, 0, 0);
    @(negedge clk);
    ack_delay = 3; bus.call = 1'b1;
    @(posedge clk); #1;
    bus.call = 1'b0;
    n = 0;
    while (!(bus.mem_req && bus.mem_addr == BASE + 8'd1) && n < 30) begin
      n++;
      @(posedge clk); #1;
    end
    chk("reached_spill_r1", (n < 30) ? 1 : 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mem_req", bus.mem_req, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_cwp", bus.cwp, 0);
    chk("abort_err", bus.err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    // a fresh overflow must spill from the stack bottom again
    do_op(1, 0, 0);
    do_op(1, 0, 0);
    do_op(1, 0, 0);
    do_op(0, 1, 0);
    do_op(0, 1, 0);
    do_op(0, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_window_ctrl.md
REG_WINDOW_CTRL -- requirements
Module: reg_window_ctrl

Interface
REQ-001 SHALL have parameter STACK_BASE, default 8'hC0: memory word address of the spill stack bottom.
REQ-002 SHALL have parameter STACK_WORDS, default 64: spill stack capacity in 16-bit words.
REQ-003 SHALL have port clk  in  1: single clock, rising edge.
REQ-004 SHALL have port rst_n  in  1: asynchronous, active-low reset.
REQ-005 SHALL have port call  in  1: request to open the next register window.
REQ-006 SHALL have port ret  in  1: request to return to the previous window.
REQ-007 SHALL have port busy  out  1: high while a request is in progress; the CPU stalls on it.
REQ-008 SHALL have port cwp  out  2: registered current window pointer.
REQ-009 SHALL have port err  out  1: sticky error flag for stack overflow or underflow.
REQ-010 SHALL have ports rf_wnd out 2, rf_reg out 2, rf_wen out 1 and rf_ldwnd out 1: register-file window, register select, write enable and window load.
REQ-011 SHALL have ports rf_rdata in 16 (register-file read data) and rf_wdata out 16 (register-file write data).
REQ-012 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out 8, mem_wdata out 16, mem_rdata in 16 and mem_ack in 1: memory request handshake.

Function
REQ-013 SHALL use this register-file model:
- 8 physical registers.
- Window w logical register r maps to physical (r+2w) mod 8.
- Adjacent windows overlap by 2 registers.
- At most 3 windows are resident at once.
REQ-014 SHALL keep internal state:
- cwp (2 bits).
- resident count (1..3).
- sp (stack word count, 0..STACK_WORDS).
- FSM state, one of IDLE, SPILL_R0, SPILL_R1, FILL_R1, FILL_R0, SWITCH.
REQ-015 In IDLE SHALL drive rf_wnd=cwp, rf_reg=0, rf_wen=0, rf_ldwnd=0, mem_req=0 and busy=0; all other states SHALL assert busy=1.
REQ-016 SHALL sample call/ret only in IDLE; requests in other states SHALL be ignored, and call and ret high together SHALL be ignored with no state change.
REQ-017 call with resident<3 SHALL go to SWITCH with target cwp+1 and resident+1.
REQ-018 call with resident=3 and sp<STACK_WORDS SHALL go to SPILL_R0.
REQ-019 call with resident=3 and sp=STACK_WORDS SHALL set err, stay IDLE and leave cwp unchanged.
REQ-020 SPILL_Rk (k=0, then 1) SHALL spill one register of the oldest window:
- Drive rf_wnd=cwp-2 (mod 4), rf_reg=k.
- Drive mem_req=1, mem_we=1, mem_addr=STACK_BASE+sp, mem_wdata=rf_rdata.
- Hold all of these stable until mem_ack.
- On mem_ack: sp increments; SPILL_R0 goes to SPILL_R1, SPILL_R1 goes to SWITCH with target cwp+1 and resident unchanged (3).
REQ-021 ret with resident>1 SHALL go to SWITCH with target cwp-1 and resident-1.
REQ-022 ret with resident=1 and sp>=2 SHALL go to FILL_R1.
REQ-023 ret with resident=1 and sp<2 SHALL set err, stay IDLE and leave cwp unchanged.
REQ-024 FILL_Rk (k=1, then 0) SHALL refill one register of the caller window:
- Drive mem_req=1, mem_we=0, mem_addr=STACK_BASE+sp-1; hold until mem_ack.
- In the mem_ack cycle only, drive rf_wen=1, rf_wnd=cwp-1 (mod 4), rf_reg=k, rf_wdata=mem_rdata.
- On mem_ack: sp decrements; FILL_R1 goes to FILL_R0, FILL_R0 goes to SWITCH with target cwp-1 and resident unchanged (1).
REQ-025 SWITCH SHALL last exactly one cycle, driving rf_wnd=target and rf_ldwnd=1; cwp SHALL load target at the end of that cycle, then the FSM returns to IDLE.
REQ-026 Window arithmetic SHALL be modulo 4 (cwp 3 + call gives 0; cwp 0 + ret gives 3).
REQ-027 A call or ret needing no memory SHALL hold busy high for exactly 1 cycle, with the new cwp visible on the next edge.
REQ-028 With zero-wait mem_ack, a spill or fill SHALL hold busy high for 3 cycles.
REQ-029 Once set, err SHALL stay high until reset.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, cwp=0, resident=1, sp=0, err=0, busy=0, mem_req=0, mem_we=0, rf_wen=0, rf_ldwnd=0.
REQ-031 Reset during a spill or fill SHALL drop mem_req in the same cycle, and the aborted transfer SHALL not be resumed.

Verification
REQ-032 From reset, call twice -> cwp=2, resident=3, mem_req never asserted, one rf_ldwnd pulse per call.
REQ-033 Third call with phys0=16'hAAAA, phys1=16'h5555 -> writes 0xC0<=AAAA then 0xC1<=5555 (rf_wnd=0), then cwp=3, sp=2.
REQ-034 Then ret x2 (no memory), then ret -> reads 0xC1 into window 0 reg1, then 0xC0 into reg0, then cwp=0, sp=0, phys0/1 restored.
REQ-035 ret right after reset -> err=1, cwp=0, no mem_req; a following legal call still executes.
REQ-036 mem_ack delayed 3 cycles during a spill -> mem_addr/mem_wdata/rf_reg stable and busy high throughout.
REQ-037 rst_n low during SPILL_R1 -> mem_req low immediately, cwp=0, sp=0, busy=0.
